// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Memory-side target for the core's system bus. It accepts block read and
//   block write requests, keeps the data in an internal word array, and
//   returns read data as BEATS-beat bursts after RESP_LAT wait cycles.
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        synchronous active-low reset
//   bus_reqcyc   request / write-data beat valid
//   bus_req      byte address on the request cycle, write data afterwards
//   bus_reqtag   [12] 1=read 0=write, [11:8] type, [7:0] opaque
//   bus_reqack   one-cycle acknowledge of the request cycle
//   bus_respcyc  read data beat valid
//   bus_resp     read data beat
//   bus_resptag  latched request tag, echoed during the burst
//   bus_respack  initiator accepts the current beat
//
// Build option
//   BUS_RESP_CRITICAL_WORD_EN : read bursts start at the requested word and
//   wrap inside the block. Without it, reads always return words 0..BEATS-1.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for bus_reqcyc; address and tag latched on accept
// ACK      | bus_reqack high for this single cycle
// WAIT     | read latency countdown (RESP_LAT cycles)
// BURST_RD | presenting read beats, advancing on bus_respack
// BURST_WR | storing write beats, advancing on bus_reqcyc

module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int BEATS          = 8,
  parameter int RESP_LAT       = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int BLK_W  = IDX_W - BEAT_W;
  // The latency counter only ever holds RESP_LAT-1 down to 0.
  localparam int LAT_W  = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = (RESP_LAT > 0) ? LAT_W'(RESP_LAT - 1) : '0;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ACK      = 3'd1;
  localparam logic [2:0] WAIT     = 3'd2;
  localparam logic [2:0] BURST_RD = 3'd3;
  localparam logic [2:0] BURST_WR = 3'd4;

  logic [2:0]                state;
  logic [BLK_W-1:0]          blk_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [BEAT_W-1:0]         beat;
  logic [LAT_W-1:0]          lat_cnt;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                      is_read;
  logic [BEAT_W-1:0]         start_off;
  logic [BEAT_W-1:0]         rd_beat_next;
  logic [IDX_W-1:0]          rd_idx;
  logic [IDX_W-1:0]          wr_idx;
  logic                      mem_we;
  logic                      unused_req_bits;

  assign is_read = tag_q[BUS_TAG_WIDTH-1];

`ifdef BUS_RESP_CRITICAL_WORD_EN
  logic [BEAT_W-1:0] off_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      off_q <= '0;
    end else if (state == IDLE && bus_reqcyc) begin
      off_q <= bus_req[3 +: BEAT_W];
    end
  end

  assign start_off = off_q;
  assign unused_req_bits = ^{bus_req[BUS_DATA_WIDTH-1:3+IDX_W], bus_req[2:0]};
`else
  assign start_off = '0;
  assign unused_req_bits = ^{bus_req[BUS_DATA_WIDTH-1:3+IDX_W], bus_req[3 +: BEAT_W], bus_req[2:0]};
`endif

  // Word fetched for the beat that will be on the bus next cycle: beat 0 when
  // the burst is starting, otherwise the one after the current beat. The
  // in-block offset wraps naturally in BEAT_W bits.
  assign rd_beat_next = (state == BURST_RD) ? beat + BEAT_W'(1) : '0;
  assign rd_idx       = {blk_q, BEAT_W'(start_off + rd_beat_next)};
  assign wr_idx       = {blk_q, beat};
  assign mem_we       = reset && (state == BURST_WR) && bus_reqcyc;

  // Word array has no reset so that contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= bus_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      blk_q       <= '0;
      tag_q       <= '0;
      beat        <= '0;
      lat_cnt     <= '0;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus_reqack <= 1'b0;
          if (bus_reqcyc) begin
            blk_q      <= bus_req[3+BEAT_W +: BLK_W];
            tag_q      <= bus_reqtag;
            beat       <= '0;
            bus_reqack <= 1'b1;
            state      <= ACK;
          end
        end

        ACK: begin
          // bus_reqcyc seen here belongs to the request just accepted.
          bus_reqack <= 1'b0;
          if (!is_read) begin
            state <= BURST_WR;
          end else if (RESP_LAT == 0) begin
            bus_respcyc <= 1'b1;
            bus_resp    <= mem[rd_idx];
            bus_resptag <= tag_q;
            state       <= BURST_RD;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (lat_cnt == '0) begin
            bus_respcyc <= 1'b1;
            bus_resp    <= mem[rd_idx];
            bus_resptag <= tag_q;
            state       <= BURST_RD;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        BURST_RD: begin
          if (bus_respack) begin
            if (beat == LAST_BEAT) begin
              bus_respcyc <= 1'b0;
              bus_resp    <= '0;
              bus_resptag <= '0;
              beat        <= '0;
              state       <= IDLE;
            end else begin
              beat     <= beat + BEAT_W'(1);
              bus_resp <= mem[rd_idx];
            end
          end
        end

        BURST_WR: begin
          if (bus_reqcyc) begin
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= IDLE;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Testbench for bus_mem_responder: directed table of read vectors, hand-written
// corner sequences (stall, write gap, resets mid-burst) and a randomized phase,
// all checked against a word-array reference model.

module tb_bus_mem_responder;

  localparam int DW        = 64;
  localparam int TW        = 13;
  localparam int MEM_WORDS = 4096;
  localparam int BEATS     = 8;
  localparam int RESP_LAT  = 4;
`ifdef BUS_RESP_CRITICAL_WORD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  typedef logic [DW-1:0] blk_t [BEATS];

  typedef struct {
    logic [DW-1:0] addr;
    logic [TW-1:0] tag;
    int            stall_beat;
    int            stall_len;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } rd_vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [MEM_WORDS];

  bus_mem_responder #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .MEM_WORDS     (MEM_WORDS),
    .BEATS         (BEATS),
    .RESP_LAT      (RESP_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int word_idx(input logic [DW-1:0] addr);
    return int'((addr >> 3) % 64'(MEM_WORDS));
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] addr, input int i);
    int idx, base, start;
    idx   = word_idx(addr);
    base  = idx - (idx % BEATS);
    start = CRIT ? (idx % BEATS) : 0;
    return mem_m[base + ((start + i) % BEATS)];
  endfunction

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_respcyc"}, 64'(bus_respcyc), 64'd0);
    chk({nm, "_reqack"},  64'(bus_reqack),  64'd0);
    chk({nm, "_resp"},    bus_resp,         64'd0);
    chk({nm, "_resptag"}, 64'(bus_resptag), 64'd0);
  endtask

  // Write burst. Beats are stored base-first. gap_beat/gap_len insert idle
  // cycles before that beat; abort_beat (>=0) applies reset instead of that beat.
  task automatic do_write(input logic [DW-1:0] addr, input logic [TW-1:0] tag, input blk_t d,
                          input int gap_beat, input int gap_len, input int abort_beat);
    int beat, gap_left, base;
    base = word_idx(addr) - (word_idx(addr) % BEATS);
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b0;
    step();
    chk("wr_reqack_c1", 64'(bus_reqack), 64'd1);
    bus_reqcyc = 1'b1; bus_req = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    chk("wr_reqack_c2", 64'(bus_reqack), 64'd0);
    beat = 0; gap_left = gap_len;
    while (beat < BEATS) begin
      if (beat == abort_beat) begin
        reset = 1'b0; bus_reqcyc = 1'b0;
        step();
        chk_idle_outputs("wr_abort");
        reset = 1'b1;
        return;
      end
      if (beat == gap_beat && gap_left > 0) begin
        bus_reqcyc = 1'b0; bus_req = 64'hDEAD_BEEF_DEAD_BEEF;
        gap_left--;
      end else begin
        bus_reqcyc = 1'b1; bus_req = d[beat];
        mem_m[base + beat] = d[beat];
        beat++;
      end
      step();
      chk("wr_no_ack", 64'(bus_reqack), 64'd0);
      chk("wr_no_resp", 64'(bus_respcyc), 64'd0);
    end
    bus_reqcyc = 1'b0;
  endtask

  // Read burst with optional respack stall, pending request during the burst
  // and reset at abort_beat.
  task automatic do_read(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                         input int stall_beat, input int stall_len, input bit hold_req,
                         input int abort_beat, output logic [DW-1:0] first, output logic [DW-1:0] last);
    int cyc, beat, stall_left;
    first = '0; last = '0;
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b1;
    step();
    cyc = 1;
    chk("rd_reqack_c1", 64'(bus_reqack), 64'd1);
    bus_reqcyc = 1'b1; bus_req = addr ^ 64'h40; bus_reqtag = tag ^ 13'h0FF;
    step();
    cyc = 2;
    bus_reqcyc = hold_req;
    while (!bus_respcyc && cyc < 2 + RESP_LAT + 20) begin
      chk("rd_wait_noack", 64'(bus_reqack), 64'd0);
      step();
      cyc++;
    end
    if (!bus_respcyc) begin
      checks++; errors++;
      $display("FAIL rd_timeout: got no respcyc by cycle %0d, expected cycle %0d", cyc, 2 + RESP_LAT);
      bus_reqcyc = 1'b0;
      return;
    end
    chk("rd_first_cycle", 64'(cyc), 64'(2 + RESP_LAT));
    beat = 0; stall_left = stall_len;
    while (beat < BEATS) begin
      chk("rd_respcyc", 64'(bus_respcyc), 64'd1);
      chk("rd_data", bus_resp, exp_word(addr, beat));
      chk("rd_tag", 64'(bus_resptag), 64'(tag));
      chk("rd_noack", 64'(bus_reqack), 64'd0);
      if (beat == 0) first = bus_resp;
      last = bus_resp;
      if (beat == abort_beat) begin
        reset = 1'b0; bus_reqcyc = 1'b0; bus_respack = 1'b0;
        step();
        chk_idle_outputs("rd_abort");
        reset = 1'b1;
        return;
      end
      if (beat == stall_beat && stall_left > 0) begin
        bus_respack = 1'b0;
        stall_left--;
      end else begin
        bus_respack = 1'b1;
        beat++;
      end
      step();
    end
    chk("rd_end_respcyc", 64'(bus_respcyc), 64'd0);
    chk("rd_end_resp", bus_resp, 64'd0);
    chk("rd_end_tag", 64'(bus_resptag), 64'd0);
    bus_reqcyc = 1'b0; bus_respack = 1'b0;
  endtask

  initial begin
    rd_vec_t vecs[6];
    blk_t da, db, dc, dr;
    logic [DW-1:0] f, l;
    int blks[4];

    for (int i = 0; i < BEATS; i++) begin
      da[i] = 64'hA0 + 64'(i);
      db[i] = 64'hB0 + 64'(i);
      dc[i] = 64'hC0 + 64'(i);
    end

    vecs[0] = '{64'h1000, 13'h1100, 2, 3, 64'hA0, 64'hA7};
    vecs[1] = '{64'h1000 + 64'(MEM_WORDS * 8), 13'h11FF, -1, 0, 64'hA0, 64'hA7};
    vecs[2] = '{64'h1028, 13'h1142, 5, 1, CRIT ? 64'hA5 : 64'hA0, CRIT ? 64'hA4 : 64'hA7};
    vecs[3] = '{64'h2000, 13'h1103, -1, 0, 64'hB0, 64'hB7};
    vecs[4] = '{64'hFFFF_0000_0000_1038, 13'h1A5A, 0, 2, CRIT ? 64'hA7 : 64'hA0, CRIT ? 64'hA6 : 64'hA7};
    vecs[5] = '{64'h2010, 13'h1F00, 7, 1, CRIT ? 64'hB2 : 64'hB0, CRIT ? 64'hB1 : 64'hB7};

    reset = 1'b0; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
    repeat (3) step();
    chk_idle_outputs("reset");
    reset = 1'b1;
    step();

    do_write(64'h1000, 13'h0100, da, -1, 0, -1);
    do_write(64'h2000, 13'h0133, db, 4, 2, -1);

    for (int v = 0; v < 6; v++) begin
      do_read(vecs[v].addr, vecs[v].tag, vecs[v].stall_beat, vecs[v].stall_len, v[0], -1, f, l);
      chk($sformatf("vec%0d_first", v), f, vecs[v].exp_first);
      chk($sformatf("vec%0d_last", v), l, vecs[v].exp_last);
    end

    do_read(64'h1000, 13'h1100, -1, 0, 1'b0, 4, f, l);
    step();
    do_read(64'h1000, 13'h1101, -1, 0, 1'b0, -1, f, l);
    chk("after_rd_reset_first", f, 64'hA0);
    chk("after_rd_reset_last", l, 64'hA7);

    do_write(64'h2000, 13'h0100, dc, -1, 0, 3);
    step();
    do_read(64'h2000, 13'h1104, -1, 0, 1'b0, -1, f, l);
    chk("partial_wr_first", f, CRIT ? 64'hC0 : 64'hC0);
    chk("partial_wr_last", l, 64'hB7);

    blks = '{0, 1, 37, 511};
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < BEATS; i++) dr[i] = {$urandom, $urandom};
      do_write(64'(blks[b] * BEATS * 8) | (64'($urandom_range(0, 255)) << 15),
               {1'b0, 4'($urandom), 8'($urandom)}, dr, $urandom_range(1, 7), $urandom_range(0, 2), -1);
    end
    for (int n = 0; n < 30; n++) begin
      logic [DW-1:0] a;
      a = (64'(blks[$urandom_range(0, 3)] * BEATS + $urandom_range(0, 7)) << 3)
          | (64'($urandom_range(0, 7)))
          | (64'($urandom_range(0, 1023)) << 15)
          | {32'($urandom), 32'h0};
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < BEATS; i++) dr[i] = {$urandom, $urandom};
        do_write(a, {1'b0, 4'($urandom), 8'($urandom)}, dr,
                 $urandom_range(1, 7), $urandom_range(0, 2), -1);
      end else begin
        do_read(a, {1'b1, 4'($urandom), 8'($urandom)}, $urandom_range(0, 7),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, f, l);
      end
    end

    step();
    chk_idle_outputs("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
